// File: rtl/loader_pkg.sv
// Shared types and defaults for the instruction flash loader.
package loader_pkg;

   localparam int unsigned LOADER_ADDR_W    = 10;
   localparam int unsigned LOADER_MAX_WORDS = 1024;
   localparam int unsigned LOADER_LEN_W     = 16;
   localparam logic [7:0]  LOADER_MAGIC     = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CHECK,
      DONE,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/instruction_flash_loader_if.sv
// Byte-stream input and flash write port of the instruction loader.
interface instruction_flash_loader_if
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W = LOADER_ADDR_W
);

   logic              ByteValid;
   logic [7:0]        ByteData;
   logic              ByteReady;
   logic              FlashEn;
   logic [ADDR_W-1:0] FlashAddr;
   logic [15:0]       FlashData;

   // Loader view: consumes bytes, produces flash writes.
   modport master (
      input  ByteValid, ByteData,
      output ByteReady, FlashEn, FlashAddr, FlashData
   );

   // Environment view: produces bytes, observes flash writes.
   modport slave (
      output ByteValid, ByteData,
      input  ByteReady, FlashEn, FlashAddr, FlashData
   );

endinterface

// File: rtl/flash_word_assembler.sv
// Pairs hi/lo data bytes into 16-bit words and keeps the running 8-bit data checksum.
module flash_word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        sync_rst,
   input  logic        clk_en,
   input  logic [7:0]  byteIn,
   input  logic        accept,
   input  logic        phase,
   input  logic        sumClear,
   output logic [15:0] word_c,
   output logic [7:0]  sum,
   output logic        wordStrobe_c
);

   logic [7:0] hiByte;

   // phase=0 latches the hi byte; both phases fold the byte into the checksum.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         hiByte <= '0;
         sum    <= '0;
      end else if (clk_en) begin
         if (sumClear) begin
            sum <= '0;
         end else if (accept) begin
            sum <= sum + byteIn;
            if (!phase) begin
               hiByte <= byteIn;
            end
         end
      end
   end

   assign word_c       = {hiByte, byteIn};
   assign wordStrobe_c = accept && phase;

endmodule

// File: rtl/instruction_flash_loader.sv
// Framed byte-stream loader: MAGIC, LEN_HI, LEN_LO, LEN words (hi,lo), SUM -> instruction flash writes.
module instruction_flash_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = LOADER_ADDR_W,
   parameter logic [7:0]  MAGIC     = LOADER_MAGIC,
   parameter int unsigned MAX_WORDS = LOADER_MAX_WORDS
)(
   input  logic                        clk,
   input  logic                        sync_rst,
   input  logic                        clk_en,
   instruction_flash_loader_if.master  bus,
   output logic                        LoadActive,
   output logic                        LoadDone,
   output logic                        LoadError,
   output logic                        CoreHold
);

   localparam int unsigned LEN_W = LOADER_LEN_W;

   loader_state_t      state, stateNxt;
   logic [LEN_W-1:0]   lenReg, lenNxt, lenFull_c;
   logic [ADDR_W-1:0]  addr, addrNxt;
   logic               flashEn, flashEnNxt;
   logic [ADDR_W-1:0]  flashAddr, flashAddrNxt;
   logic [15:0]        flashData, flashDataNxt;
   logic               activeNxt, doneNxt, errorNxt;
   logic               accept_c;
   logic               asmAccept_c, asmPhase_c, asmClear_c;
   logic [15:0]        asmWord_c;
   logic [7:0]         asmSum;
   logic               asmStrobe_c;

   // One-cycle bubble after every write keeps FlashAddr/FlashData stable for the strobe.
   assign bus.ByteReady = !flashEn;
   assign accept_c      = bus.ByteValid && !flashEn && clk_en;
   assign lenFull_c     = {lenReg[LEN_W-1:8], bus.ByteData};

   assign asmPhase_c  = (state == DATA_LO);
   assign asmAccept_c = accept_c && ((state == DATA_HI) || (state == DATA_LO));
   assign asmClear_c  = accept_c && (state == LEN_LO);

   flash_word_assembler u_asm (
      .clk          (clk),
      .sync_rst     (sync_rst),
      .clk_en       (clk_en),
      .byteIn       (bus.ByteData),
      .accept       (asmAccept_c),
      .phase        (asmPhase_c),
      .sumClear     (asmClear_c),
      .word_c       (asmWord_c),
      .sum          (asmSum),
      .wordStrobe_c (asmStrobe_c)
   );

   // State and output registers; frozen whenever clk_en is low.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state      <= IDLE;
         lenReg     <= '0;
         addr       <= '0;
         flashEn    <= 1'b0;
         flashAddr  <= '0;
         flashData  <= '0;
         LoadActive <= 1'b0;
         LoadDone   <= 1'b0;
         LoadError  <= 1'b0;
      end else if (clk_en) begin
         state      <= stateNxt;
         lenReg     <= lenNxt;
         addr       <= addrNxt;
         flashEn    <= flashEnNxt;
         flashAddr  <= flashAddrNxt;
         flashData  <= flashDataNxt;
         LoadActive <= activeNxt;
         LoadDone   <= doneNxt;
         LoadError  <= errorNxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      stateNxt     = state;
      lenNxt       = lenReg;
      addrNxt      = addr;
      flashEnNxt   = 1'b0;
      flashAddrNxt = flashAddr;
      flashDataNxt = flashData;
      activeNxt    = LoadActive;
      doneNxt      = LoadDone;
      errorNxt     = LoadError;

      if (accept_c) begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (bus.ByteData == MAGIC) begin
                  stateNxt  = LEN_HI;
                  activeNxt = 1'b1;
                  doneNxt   = 1'b0;
                  errorNxt  = 1'b0;
               end
            end
            LEN_HI: begin
               lenNxt   = {bus.ByteData, lenReg[7:0]};
               stateNxt = LEN_LO;
            end
            LEN_LO: begin
               lenNxt = lenFull_c;
               if ((lenFull_c == '0) || (32'(lenFull_c) > MAX_WORDS)) begin
                  stateNxt  = ERROR;
                  activeNxt = 1'b0;
                  errorNxt  = 1'b1;
               end else begin
                  stateNxt = DATA_HI;
                  addrNxt  = '0;
               end
            end
            DATA_HI: begin
               stateNxt = DATA_LO;
            end
            DATA_LO: begin
               flashEnNxt   = asmStrobe_c;
               flashAddrNxt = addr;
               flashDataNxt = asmWord_c;
               addrNxt      = addr + ADDR_W'(1);
               if (LEN_W'(addr) == (lenReg - LEN_W'(1))) begin
                  stateNxt = CHECK;
               end else begin
                  stateNxt = DATA_HI;
               end
            end
            CHECK: begin
               activeNxt = 1'b0;
               if (bus.ByteData == asmSum) begin
                  stateNxt = DONE;
                  doneNxt  = 1'b1;
               end else begin
                  stateNxt = ERROR;
                  errorNxt = 1'b1;
               end
            end
            default: begin
               stateNxt = IDLE;
            end
         endcase
      end
   end

   assign bus.FlashEn   = flashEn;
   assign bus.FlashAddr = flashAddr;
   assign bus.FlashData = flashData;
   assign CoreHold      = !LoadDone;

endmodule
